// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a fixed window
// of GATE_CYCLES system clocks and publishes the count once per window.
//
// Ports:
//   Clk      - system clock, all logic on its rising edge
//   Reset_n  - asynchronous active-low reset, clears all state
//   Enable   - 1 = measure continuously, 0 = abort / stay idle
//   Sig_In   - asynchronous signal under measurement
//   Freq_Out - edge count of the last completed window (saturating)
//   Valid    - one-clock pulse when Freq_Out updates
//   Overflow - last completed window saturated the counter
//   Busy     - high while a window is in progress
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned COUNT_W     = 27,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Enable,
  input  logic               Sig_In,
  output logic [COUNT_W-1:0] Freq_Out,
  output logic               Valid,
  output logic               Overflow,
  output logic               Busy
);

  localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GateW-1:0]   GateLast = GateW'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CntMax   = '1;

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e               state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 prev_q;
  logic [GateW-1:0]     gate_q;
  logic [COUNT_W-1:0]   cnt_q;
  logic                 sat_q;
  logic [COUNT_W-1:0]   freq_q;
  logic                 valid_q;
  logic                 ovf_q;
  logic                 busy_q;

  logic                 sync_out;
  logic                 sig_edge;
  logic                 cnt_full;
  logic                 sat_hit;
  logic                 is_last;
  logic [COUNT_W-1:0]   cnt_next;

  // Synchroniser and edge register run in every state so a window never
  // starts with a stale edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Sig_In};
      prev_q <= sync_out;
    end
  end

  always_comb begin
    sync_out = sync_q[SYNC_STAGES-1];
    sig_edge = sync_out & ~prev_q;
    cnt_full = (cnt_q == CntMax);
    sat_hit  = sig_edge & cnt_full;
    is_last  = (gate_q == GateLast);
    cnt_next = cnt_q;
    if (sig_edge && !cnt_full) begin
      cnt_next = cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      gate_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          gate_q <= '0;
          cnt_q  <= '0;
          sat_q  <= 1'b0;
          if (Enable) begin
            state_q <= StMeasure;
            busy_q  <= 1'b1;
          end
        end
        StMeasure: begin
          if (is_last) begin
            // An edge on the terminal cycle belongs to the closing window.
            freq_q  <= cnt_next;
            ovf_q   <= sat_q | sat_hit;
            valid_q <= 1'b1;
            gate_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            if (!Enable) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else if (!Enable) begin
            // Abort: drop the partial window, keep the last published result.
            state_q <= StIdle;
            busy_q  <= 1'b0;
            gate_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
          end else begin
            gate_q <= gate_q + GateW'(1);
            cnt_q  <= cnt_next;
            sat_q  <= sat_q | sat_hit;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Freq_Out = freq_q;
  assign Valid    = valid_q;
  assign Overflow = ovf_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

  localparam int G  = 100;
  localparam int SS = 2;

  logic       Clk;
  logic       Reset_n;
  logic       Enable;
  logic       Sig_In;
  logic [7:0] freq8;
  logic [4:0] freq5;
  logic       valid8, valid5, ovf8, ovf5, busy8, busy5;

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(8), .SYNC_STAGES(SS)) dut8 (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Enable   (Enable),
    .Sig_In   (Sig_In),
    .Freq_Out (freq8),
    .Valid    (valid8),
    .Overflow (ovf8),
    .Busy     (busy8)
  );

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(5), .SYNC_STAGES(SS)) dut5 (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Enable   (Enable),
    .Sig_In   (Sig_In),
    .Freq_Out (freq5),
    .Valid    (valid5),
    .Overflow (ovf5),
    .Busy     (busy5)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  // Reference model: samples of Sig_In seen at each clock (newest first),
  // the window in progress, and the last published results per counter width.
  logic hist [0:7];
  bit   m_busy;
  int   m_pos;
  int   m_cnt;
  bit   m_valid;
  int   m_f8, m_f5;
  bit   m_o8, m_o5;

  int t  = 0;
  int ph = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) hist[k] = 1'b0;
    m_busy = 0; m_pos = 0; m_cnt = 0; m_valid = 0;
    m_f8 = 0; m_f5 = 0; m_o8 = 0; m_o5 = 0;
  endtask

  // One clock of the model: an input rising edge is counted SS+1 samples later.
  task automatic model_step();
    bit det;
    det = hist[SS-1] & ~hist[SS];
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = Sig_In;
    m_valid = 0;
    if (!m_busy) begin
      if (Enable) begin
        m_busy = 1; m_pos = 0; m_cnt = 0;
      end
    end else begin
      m_cnt += int'(det);
      if (m_pos == G - 1) begin
        m_f8 = (m_cnt > 255) ? 255 : m_cnt;
        m_o8 = (m_cnt > 255);
        m_f5 = (m_cnt > 31) ? 31 : m_cnt;
        m_o5 = (m_cnt > 31);
        m_valid = 1;
        m_pos = 0; m_cnt = 0;
        m_busy = Enable;
      end else if (!Enable) begin
        m_busy = 0; m_pos = 0; m_cnt = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  // per: 0 = low, 1 = high, <0 = random bits, else square wave of that period.
  function automatic logic gen(input int per);
    if (per == 0) return 1'b0;
    if (per == 1) return 1'b1;
    if (per < 0) return 1'($urandom_range(0, 1));
    return (((t + ph) % per) < (per / 2));
  endfunction

  task automatic cyc(input logic en, input logic sig);
    Enable = en;
    Sig_In = sig;
    @(posedge Clk);
    if (Reset_n) model_step();
    else model_reset();
    t++;
    @(negedge Clk);
  endtask

  task automatic run_to_valid(input logic en, input int per, output int ncyc);
    bit seen;
    seen = 0;
    ncyc = 0;
    while (!seen && ncyc < 300) begin
      cyc(en, gen(per));
      ncyc++;
      seen = (valid8 === 1'b1);
    end
    chk("valid_seen", 32'(seen), 1);
  endtask

  task automatic do_reset(input int ncyc);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_freq8", 32'(freq8), 0);
    chk("rst_freq5", 32'(freq5), 0);
    chk("rst_valid", 32'(valid8), 0);
    chk("rst_ovf5", 32'(ovf5), 0);
    chk("rst_busy", 32'(busy8), 0);
    for (int i = 0; i < ncyc; i++) cyc(Enable, 1'b0);
    Reset_n = 1'b1;
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("valid8", 32'(valid8), 32'(m_valid));
      chk("busy8", 32'(busy8), 32'(m_busy));
      chk("freq8", 32'(freq8), 32'(m_f8));
      chk("ovf8", 32'(ovf8), 32'(m_o8));
      chk("valid5", 32'(valid5), 32'(m_valid));
      chk("busy5", 32'(busy5), 32'(m_busy));
      chk("freq5", 32'(freq5), 32'(m_f5));
      chk("ovf5", 32'(ovf5), 32'(m_o5));
    end
  end

  initial begin
    int n;
    int per;
    logic en;
    Enable  = 1'b0;
    Sig_In  = 1'b0;
    Reset_n = 1'b1;
    model_reset();
    #1 Reset_n = 1'b0;
    @(negedge Clk);
    cmp_en = 1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("init_freq8", 32'(freq8), 0);
    chk("init_busy", 32'(busy8), 0);
    chk("init_valid", 32'(valid8), 0);
    chk("init_ovf8", 32'(ovf8), 0);
    Reset_n = 1'b1;

    // Steady 10-clock period: 10 edges per window, back-to-back windows.
    run_to_valid(1'b1, 10, n);
    run_to_valid(1'b1, 10, n);
    chk("p10_freq8", 32'(freq8), 10);
    chk("p10_ovf8", 32'(ovf8), 0);
    run_to_valid(1'b1, 10, n);
    chk("p10_spacing", 32'(n), 100);
    chk("p10_freq5", 32'(freq5), 10);

    // Sweep phase so a detected edge lands on the terminal cycle at some point.
    for (int p = 0; p < 10; p++) begin
      ph = p;
      run_to_valid(1'b1, 10, n);
      run_to_valid(1'b1, 10, n);
      chk("phase_freq8", 32'(freq8), 10);
    end
    ph = 0;

    // Abort mid-window at gate count 50.
    n = 0;
    while (m_pos != 50 && n < 300) begin
      cyc(1'b1, gen(10));
      n++;
    end
    chk("pos50_reached", 32'(m_pos), 50);
    cyc(1'b0, gen(10));
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_valid", 32'(valid8), 0);
    chk("abort_freq8", 32'(freq8), 10);
    for (int i = 0; i < 5; i++) cyc(1'b0, gen(10));
    chk("idle_freq8", 32'(freq8), 10);
    run_to_valid(1'b1, 10, n);
    chk("restart_latency", 32'(n), 101);

    // Constant inputs.
    run_to_valid(1'b1, 0, n);
    run_to_valid(1'b1, 0, n);
    chk("low_freq8", 32'(freq8), 0);
    run_to_valid(1'b1, 1, n);
    run_to_valid(1'b1, 1, n);
    run_to_valid(1'b1, 1, n);
    chk("high_freq8", 32'(freq8), 0);

    // Period 2: 50 edges saturates the 5-bit counter.
    run_to_valid(1'b1, 2, n);
    run_to_valid(1'b1, 2, n);
    chk("sat_freq5", 32'(freq5), 31);
    chk("sat_ovf5", 32'(ovf5), 1);
    chk("sat_freq8", 32'(freq8), 50);
    chk("sat_ovf8", 32'(ovf8), 0);
    run_to_valid(1'b1, 10, n);
    run_to_valid(1'b1, 10, n);
    chk("unsat_freq5", 32'(freq5), 10);
    chk("unsat_ovf5", 32'(ovf5), 0);

    // Reset mid-window, then resume.
    for (int i = 0; i < 37; i++) cyc(1'b1, gen(10));
    Enable = 1'b1;
    do_reset(3);
    run_to_valid(1'b1, 10, n);
    chk("post_reset_latency", 32'(n), 101);

    // Random periods, random bit streams and random Enable drops.
    en  = 1'b1;
    per = 10;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        per = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(2, 20));
        ph  = int'($urandom_range(0, 19));
      end
      if (en && $urandom_range(0, 249) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      cyc(en, gen(per));
    end

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Reciprocal of the clock divider: counts rising edges of an external, asynchronous signal over a fixed gate window of system clocks.
- Reports the edge count once per window, so with a 1 s gate at 100 MHz the result is the frequency in Hz.
- Feeds the seven-segment display path, which reads Freq_Out when Valid pulses.

Parameters:
- GATE_CYCLES, 100_000_000: system clocks per measurement window; must be ≥ 4.
- COUNT_W, 27: width of the edge counter and of Freq_Out.
- SYNC_STAGES, 2: flip-flop stages on Sig_In; must be ≥ 2.

Ports:
- Clk  input  1  system clock, all logic on its rising edge
- Reset_n  input  1  asynchronous reset, active-low; clears all state
- Enable  input  1  synchronous run control; 1 = measure continuously
- Sig_In  input  1  asynchronous signal under measurement
- Freq_Out  output  COUNT_W  edge count of the last completed window
- Valid  output  1  one-clock pulse when Freq_Out updates
- Overflow  output  1  last completed window saturated the counter
- Busy  output  1  high while a window is in progress

Behaviour:
- Reset (Reset_n=0, asynchronous): all of the following clear immediately and stay cleared until Reset_n=1.
  - State = IDLE.
  - Sync chain, edge-detect register, gate counter and edge counter = 0.
  - Freq_Out = 0, Valid = 0, Overflow = 0, Busy = 0.
- Input conditioning:
  - Sig_In passes through SYNC_STAGES flops, then a previous-value register.
  - edge = sync_out & ~prev.
  - Latency from a Sig_In rising edge to the counter increment is SYNC_STAGES+1 clocks.
  - The sync chain and prev run in every state, including IDLE, so no false edge appears when a window starts.
- State IDLE:
  - Busy = 0; gate counter and edge counter are held at 0.
  - Enable=1 → MEASURE on the next clock.
- State MEASURE:
  - Busy = 1.
  - Gate counter runs 0..GATE_CYCLES-1, incrementing every clock.
  - Edge counter increments on each cycle where edge=1.
  - It saturates at 2^COUNT_W-1 and never wraps; the first increment attempt at all-ones sets an internal sat flag.
  - Terminal cycle (gate counter = GATE_CYCLES-1):
    - Freq_Out <= edge counter + edge, saturating; an edge on the terminal cycle belongs to the closing window.
    - Overflow <= sat flag (or saturation on this cycle).
    - Valid = 1 on the following cycle, for exactly one cycle.
    - Gate counter, edge counter and sat flag restart at 0 on the same clock.
    - If Enable=1, stay in MEASURE with no dead cycle, so no edge is lost between windows.
    - If Enable=0 at the terminal cycle, the result is still published, then the block goes to IDLE.
- Enable drops mid-window (not the terminal cycle):
  - Abort and go to IDLE next clock; counters clear.
  - No Valid; Freq_Out and Overflow keep their last published values.
- Enable re-asserted: a fresh window starts from gate count 0. The first window after IDLE may miss edges that are still in the sync pipeline; this is accepted.
- Sig_In frequency limit:
  - Must stay below Clk/2 with high and low each ≥ 1 clock.
  - Faster inputs under-count; this is not detected.
- Freq_Out stays stable between Valid pulses; consumers sample on Valid.
- Reset asserted mid-window: everything clears immediately; no Valid is generated.

Test Plan:
(all with GATE_CYCLES=100, COUNT_W=8, SYNC_STAGES=2)
- Reset, Enable=1, Sig_In period 10 clocks at 50% duty → from the second window onward, Valid pulses every 100 clocks and Freq_Out=10, Overflow=0; Busy=1 throughout; no Valid gaps.
- Sig_In held at 0, Enable=1 → every Valid reports Freq_Out=0; then Sig_In held at 1 → next steady window reports 0 after at most one window reporting 1.
- COUNT_W=5 with Sig_In period 2 (50 edges per window) → Freq_Out=31, Overflow=1; then Sig_In period 10 → next full window gives Freq_Out=10, Overflow=0.
- Drop Enable at gate count 50 after a prior result of 10 → no Valid, Busy=0 next clock, Freq_Out stays 10; re-assert Enable → a new 100-clock window is followed by Valid.
- Place a Sig_In rising edge so its detected edge lands exactly on the terminal cycle → that edge is counted in the closing window, and the next window's count excludes it (period-10 input still gives 10,10).
- Assert Reset_n=0 for 3 clocks mid-window → Freq_Out=0, Valid=0, Overflow=0, Busy=0 asynchronously; release with Enable=1 → measurement resumes and Valid follows 100 clocks later.
